// File: rtl/aes_pkg.sv
// Shared AES byte-ordering definitions.
// Bit order is big-endian: byte k of a state occupies bits [8k:8k+7].
// col2row_idx maps a row-major index 4r+c to the column-major index
// 4c+r. Transposing twice gives back the original index, so the
// row-to-column loader uses this same function.
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;

    typedef logic [0:STATE_W-1] state_t;
    typedef logic [0:BYTE_W-1]  byte_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } unl_state_e;

    // idx[0:1] is the row and idx[2:3] is the column; swapping them transposes.
    function automatic logic [0:3] col2row_idx(input logic [0:3] idx);
        return {idx[2:3], idx[0:1]};
    endfunction

endpackage

// File: rtl/state_byte_sel.sv
// Combinational 16:1 byte selector.
// Ports:
//   i_state - 128-bit state, byte k = i_state[8k:8k+7]
//   i_idx   - byte index 0..15
//   o_byte  - selected byte
module state_byte_sel
    import aes_pkg::*;
(
    input  state_t     i_state,
    input  logic [0:3] i_idx,
    output byte_t      o_byte
);

    logic [6:0] w_bit_base;

    assign w_bit_base = {i_idx, 3'b000};
    assign o_byte     = i_state[w_bit_base +: BYTE_W];

endmodule

// File: rtl/state_col2row_unloader.sv
// Accepts one 128-bit AES state and emits it as 16 bytes on a byte
// stream. With COL_MAJOR=1 the bytes come out in row-major order;
// with COL_MAJOR=0 they come out in index order.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_state/valid/ready - 128-bit block input handshake
//   out_byte/valid/ready - byte output handshake
//   out_last            - marks the 16th byte of a block
//   busy                - a block is held and not fully emitted
module state_col2row_unloader
    import aes_pkg::*;
#(
    parameter bit COL_MAJOR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:7]   out_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    unl_state_e r_state;
    logic [0:3] r_idx;
    state_t     r_hold;
    byte_t      r_out_byte;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_busy;

    logic [0:3] w_idx_next;
    logic [0:3] w_sel_idx;
    byte_t      w_sel_byte;
    logic       w_in_hs;
    logic       w_out_hs;
    logic       w_at_last;

    assign w_at_last  = (r_idx == 4'd15);
    assign w_idx_next = r_idx + 4'd1;
    assign w_sel_idx  = COL_MAJOR ? col2row_idx(w_idx_next) : w_idx_next;

    // A new block is taken when idle, or on the cycle the last byte leaves.
    assign in_ready = !rst && ((r_state == S_IDLE) || (w_at_last && out_ready));
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    // Selects the byte to present after the current one is accepted.
    state_byte_sel u_sel (
        .i_state (r_hold),
        .i_idx   (w_sel_idx),
        .o_byte  (w_sel_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_hold      <= '0;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_in_hs) begin
            // Index 0 maps to held byte 0 in both orderings.
            r_state     <= S_SEND;
            r_idx       <= 4'd0;
            r_hold      <= in_state;
            r_out_byte  <= in_state[0:7];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b1;
        end else if (r_state == S_SEND && w_out_hs) begin
            if (w_at_last) begin
                r_state     <= S_IDLE;
                r_idx       <= 4'd0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                r_idx      <= w_idx_next;
                r_out_byte <= w_sel_byte;
                r_out_last <= (w_idx_next == 4'd15);
            end
        end
    end

    assign out_byte  = r_out_byte;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_state_col2row_unloader.sv
module tb_state_col2row_unloader;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:127] in_state;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready1, out_valid1, out_last1, busy1;
    logic [0:7]   out_byte1;
    logic         in_ready0, out_valid0, out_last0, busy0;
    logic [0:7]   out_byte0;

    int checks = 0;
    int errors = 0;

    // Expected bytes still to be emitted, one queue per ordering.
    logic [7:0] q1[$];
    logic [7:0] q0[$];

    always #5 clk = ~clk;

    state_col2row_unloader #(.COL_MAJOR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_state(in_state), .in_valid(in_valid),
        .in_ready(in_ready1), .out_byte(out_byte1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_last(out_last1), .busy(busy1)
    );

    state_col2row_unloader #(.COL_MAJOR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_state(in_state), .in_valid(in_valid),
        .in_ready(in_ready0), .out_byte(out_byte0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_last(out_last0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Row-major emission of a column-major block: element (r,c) is byte 4c+r.
    task automatic push_block(input logic [0:127] blk);
        for (int k = 0; k < 16; k++) begin
            q1.push_back(blk[8*(4*(k%4) + k/4) +: 8]);
            q0.push_back(blk[8*k +: 8]);
        end
    endtask

    // One clock cycle: drive, check against the model, clock, update the model.
    task automatic cyc(input logic v, input logic [0:127] d, input logic ordy,
                       input logic r, output logic acc);
        logic ev, erdy;
        in_valid  = v;
        in_state  = d;
        out_ready = ordy;
        rst       = r;
        #1;
        ev   = (q1.size() != 0);
        erdy = !r && ((q1.size() == 0) || (q1.size() == 1 && ordy));
        chk("in_ready1", {7'd0, in_ready1}, {7'd0, erdy});
        chk("in_ready0", {7'd0, in_ready0}, {7'd0, erdy});
        if (!r) begin
            chk("out_valid1", {7'd0, out_valid1}, {7'd0, ev});
            chk("out_valid0", {7'd0, out_valid0}, {7'd0, ev});
            chk("busy1", {7'd0, busy1}, {7'd0, ev});
            chk("busy0", {7'd0, busy0}, {7'd0, ev});
            chk("out_last1", {7'd0, out_last1}, {7'd0, ev && q1.size() == 1});
            chk("out_last0", {7'd0, out_last0}, {7'd0, ev && q0.size() == 1});
            if (ev) begin
                chk("out_byte1", out_byte1, q1[0]);
                chk("out_byte0", out_byte0, q0[0]);
            end
        end
        acc = v && erdy;
        @(posedge clk);
        if (r) begin
            q1.delete();
            q0.delete();
        end else begin
            if (ev && ordy) begin
                void'(q1.pop_front());
                void'(q0.pop_front());
            end
            if (acc) push_block(d);
        end
        @(negedge clk);
    endtask

    task automatic drain(input bit rnd);
        logic acc;
        int n = 0;
        while (q1.size() != 0 && n < 400) begin
            cyc(1'b0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, acc);
            n++;
        end
        checks++;
        assert (q1.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout observed=%0d expected=0", q1.size());
        end
    endtask

    function automatic logic [0:127] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [0:127] BLK_A = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [0:127] BLK_B = 128'h101112131415161718191A1B1C1D1E1F;

    initial begin
        logic acc;
        logic [0:127] blks[4];
        int bi;
        int guard;

        // Reset; in_ready must be low while rst is high.
        cyc(1'b0, '0, 1'b1, 1'b1, acc);
        cyc(1'b0, '0, 1'b1, 1'b1, acc);
        chk("rst_byte1", out_byte1, 8'h00);
        chk("rst_byte0", out_byte0, 8'h00);
        cyc(1'b0, '0, 1'b1, 1'b0, acc);

        // Single block, out_ready high: both orderings.
        cyc(1'b1, BLK_A, 1'b1, 1'b0, acc);
        chk("accept_a", {7'd0, acc}, 8'd1);
        drain(1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, acc);

        // Random data with random out_ready stalls.
        for (int t = 0; t < 3; t++) begin
            cyc(1'b1, rnd_blk(), 1'($urandom_range(0, 1)), 1'b0, acc);
            drain(1'b1);
        end

        // Back-to-back blocks with in_valid held; no bubble between blocks.
        blks[0] = BLK_A; blks[1] = BLK_B; blks[2] = rnd_blk(); blks[3] = rnd_blk();
        bi = 0;
        guard = 0;
        while (bi < 2 && guard < 100) begin
            cyc(1'b1, blks[bi], 1'b1, 1'b0, acc);
            if (acc) bi++;
            guard++;
        end
        while (bi < 4 && guard < 300) begin
            cyc(1'b1, blks[bi], 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) bi++;
            guard++;
        end
        checks++;
        assert (bi == 4) else begin
            errors++;
            $error("FAIL b2b_accept observed=%0d expected=4", bi);
        end
        drain(1'b1);

        // Reset after 5 bytes of A; B must then start from its byte 0.
        cyc(1'b1, BLK_A, 1'b1, 1'b0, acc);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        cyc(1'b0, '0, 1'b1, 1'b1, acc);
        cyc(1'b0, '0, 1'b0, 1'b0, acc);
        cyc(1'b1, BLK_B, 1'b1, 1'b0, acc);
        drain(1'b0);

        // in_valid pulse while busy at idx=3 is ignored.
        cyc(1'b1, BLK_A, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        cyc(1'b1, BLK_B, 1'b0, 1'b0, acc);
        chk("pulse_ignored", {7'd0, acc}, 8'd0);
        cyc(1'b1, BLK_B, 1'b1, 1'b0, acc);
        drain(1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
